// File: rtl/vga_sync_gen.sv
// VGA pixel timing source: free-running x/y counters, sync decode, and a delay line that
// lines sync/blanking up with the renderer's color so all pins change on the same edge.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned PIPE_DLY = 1
) (
  input  logic        VGA_clk,
  input  logic        rst_n,
  input  logic [2:0]  color,
  output logic [9:0]  xCount,
  output logic [9:0]  yCount,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb
);

  localparam int unsigned CW      = 10;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC;

  logic [CW-1:0]       x_q, x_d;
  logic [CW-1:0]       y_q, y_d;
  logic                act0, hs0, vs0;
  logic [PIPE_DLY-1:0] act_pipe_q, hs_pipe_q, vs_pipe_q;
  logic                hsync_q, vsync_q;
  logic [11:0]         rgb_q;

  // Raster counters: y advances only when x wraps.
  always_comb begin
    x_d = x_q + CW'(1);
    y_d = y_q;
    if (x_q == CW'(H_TOTAL - 1)) begin
      x_d = '0;
      if (y_q == CW'(V_TOTAL - 1)) begin
        y_d = '0;
      end else begin
        y_d = y_q + CW'(1);
      end
    end
  end

  // Undelayed decode of the current coordinate.
  always_comb begin
    act0 = (x_q < CW'(H_ACTIVE)) && (y_q < CW'(V_ACTIVE));
    hs0  = !((x_q >= CW'(HS_BEG)) && (x_q < CW'(HS_END)));
    vs0  = !((y_q >= CW'(VS_BEG)) && (y_q < CW'(VS_END)));
  end

  always_ff @(posedge VGA_clk) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      act_pipe_q <= '0;
      hs_pipe_q  <= '1;
      vs_pipe_q  <= '1;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      rgb_q      <= '0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      act_pipe_q[0] <= act0;
      hs_pipe_q[0]  <= hs0;
      vs_pipe_q[0]  <= vs0;
      for (int i = 1; i < int'(PIPE_DLY); i++) begin
        act_pipe_q[i] <= act_pipe_q[i-1];
        hs_pipe_q[i]  <= hs_pipe_q[i-1];
        vs_pipe_q[i]  <= vs_pipe_q[i-1];
      end
      // Last delay stage meets the renderer's color for this coordinate here.
      hsync_q <= hs_pipe_q[PIPE_DLY-1];
      vsync_q <= vs_pipe_q[PIPE_DLY-1];
      rgb_q   <= act_pipe_q[PIPE_DLY-1] ? {{4{color[2]}}, {4{color[1]}}, {4{color[0]}}} : 12'h000;
    end
  end

  assign xCount      = x_q;
  assign yCount      = y_q;
  assign frame_start = rst_n && (x_q == '0) && (y_q == '0);
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb         = rgb_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: a full-size 640x480 instance and a shrunken raster
// (deeper delay line) share stimulus; expectations come from raster arithmetic on cycle count.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        fs;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } out_t;

  typedef struct packed {
    out_t        a;
    out_t        b;
    logic [31:0] k;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  color;
  logic [9:0]  xa, ya, xb, yb;
  logic        fsa, hsa, vsa, fsb, hsb, vsb;
  logic [11:0] rgba, rgbb;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   k     = 0;

  always #5 clk = ~clk;

  vga_sync_gen u_dut_a (
    .VGA_clk(clk), .rst_n(rst_n), .color(color),
    .xCount(xa), .yCount(ya), .frame_start(fsa), .hsync(hsa), .vsync(vsa), .rgb(rgba)
  );

  vga_sync_gen #(
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2), .PIPE_DLY(2)
  ) u_dut_b (
    .VGA_clk(clk), .rst_n(rst_n), .color(color),
    .xCount(xb), .yCount(yb), .frame_start(fsb), .hsync(hsb), .vsync(vsb), .rgb(rgbb)
  );

  // Expected pins in cycle k (k = edges since the last reset edge).
  function automatic out_t model(input int inst, input int kk, input bit rh, input logic [2:0] col);
    out_t m;
    int ha, hf, hw, hb, va, vf, vw, vb, p, ht, vt, c, x, y;
    if (inst == 0) begin
      ha = 640; hf = 16; hw = 96; hb = 48; va = 480; vf = 10; vw = 2; vb = 33; p = 1;
    end else begin
      ha = 20; hf = 3; hw = 5; hb = 4; va = 10; vf = 2; vw = 3; vb = 2; p = 2;
    end
    ht    = ha + hf + hw + hb;
    vt    = va + vf + vw + vb;
    m.x   = 10'(kk % ht);
    m.y   = 10'((kk / ht) % vt);
    m.fs  = rh && ((kk % (ht * vt)) == 0);
    m.hs  = 1'b1;
    m.vs  = 1'b1;
    m.rgb = 12'h000;
    if (kk > p) begin
      c    = kk - p - 1;
      x    = c % ht;
      y    = (c / ht) % vt;
      m.hs = !((x >= ha + hf) && (x < ha + hf + hw));
      m.vs = !((y >= va + vf) && (y < va + vf + vw));
      if ((x < ha) && (y < va)) m.rgb = {{4{col[2]}}, {4{col[1]}}, {4{col[0]}}};
    end
    return m;
  endfunction

  task automatic check_out(input string nm, input int kk, input out_t exp, input out_t got);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s k=%0d got x=%0d y=%0d fs=%0b hs=%0b vs=%0b rgb=%h expected x=%0d y=%0d fs=%0b hs=%0b vs=%0b rgb=%h",
               nm, kk, got.x, got.y, got.fs, got.hs, got.vs, got.rgb,
               exp.x, exp.y, exp.fs, exp.hs, exp.vs, exp.rgb);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and queue what the next edge must produce.
  task automatic step(input bit r, input int mode);
    exp_t e;
    bit   was_rst;
    int   c;
    @(negedge clk);
    was_rst = !rst_n;
    rst_n   = r;
    k       = r ? k + 1 : 0;
    case (mode)
      0: color = 3'($urandom);
      1: color = 3'b101;
      default: begin
        c     = k - 2;
        color = (c < 0) ? 3'b000 : 3'(((c % 800) + ((c / 800) % 525)) % 8);
      end
    endcase
    e.a = model(0, k, r, color);
    e.b = model(1, k, r, color);
    e.k = 32'(k);
    sb.push_back(e);
    if (r && was_rst) begin
      #1;
      n_cmp++;
      if (!(fsa && fsb && xa == 10'd0 && ya == 10'd0 && xb == 10'd0 && yb == 10'd0)) begin
        n_err++;
        $display("FAIL release_frame_start got fsa=%0b fsb=%0b xa=%0d xb=%0d expected fs=1 x=0", fsa, fsb, xa, xb);
      end
    end
  endtask

  // Monitor: compares queued expectations against the pins just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_out("dut_a", int'(e.k), e.a, out_t'({xa, ya, fsa, hsa, vsa, rgba}));
        check_out("dut_b", int'(e.k), e.b, out_t'({xb, yb, fsb, hsb, vsb, rgbb}));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    color = 3'b000;
    repeat (3)    step(1'b0, 0);
    repeat (1800) step(1'b1, 0);
    repeat (900)  step(1'b1, 1);
    repeat (900)  step(1'b1, 2);
    while ((k % 800) != 300) step(1'b1, 0);
    repeat (3)    step(1'b0, 0);
    repeat (1700) step(1'b1, 0);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
